// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// Handshake: a transfer happens on any rising edge where valid & ready are both 1.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [3:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  output logic        div_res_valid,
  input  logic        div_res_ready,
  output logic [31:0] div_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic        signed_f;
  logic        mod_f;
  logic        src1_sign;
  logic        src2_sign;
  logic        zero_f;
  logic [31:0] raw_src1;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [4:0]  cnt;
  logic        iter_done;
  logic [31:0] result;

  logic        accept;
  logic        op_signed;
  logic        op_mod;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic        keep;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] final_res;

  assign accept = (state == IDLE) & div_valid & ~flush;

  // Malformed op encodings (unsigned and signed bits both set) fall back to unsigned.
  assign op_signed = (div_op[0] | div_op[1]) & ~(div_op[2] | div_op[3]);
  assign op_mod    = div_op[1] | div_op[3];
  assign mag1      = (op_signed & div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
  assign mag2      = (op_signed & div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;

  // rem[32] is always 0 between iterations; keeping it in the trial keeps the
  // subtraction wide enough that bit 33 is a true sign bit.
  assign shifted = {rem, dividend[31]};
  assign trial   = shifted - {2'b00, divisor};
  assign keep    = ~trial[33];

  always_comb begin
    q_fix = (signed_f & (src1_sign ^ src2_sign)) ? (~quo + 32'd1) : quo;
    r_fix = (signed_f & src1_sign) ? (~rem[31:0] + 32'd1) : rem[31:0];
    if (zero_f) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = raw_src1;
    end
    final_res = mod_f ? r_fix : q_fix;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (iter_done) state_next = DONE;
      DONE:    if (div_res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      signed_f  <= 1'b0;
      mod_f     <= 1'b0;
      src1_sign <= 1'b0;
      src2_sign <= 1'b0;
      zero_f    <= 1'b0;
      raw_src1  <= 32'd0;
      dividend  <= 32'd0;
      divisor   <= 32'd0;
      rem       <= 33'd0;
      quo       <= 32'd0;
      cnt       <= 5'd0;
      iter_done <= 1'b0;
      result    <= 32'd0;
    end else if (accept) begin
      signed_f  <= op_signed;
      mod_f     <= op_mod;
      src1_sign <= div_src1[31];
      src2_sign <= div_src2[31];
      zero_f    <= (div_src2 == 32'd0);
      raw_src1  <= div_src1;
      dividend  <= mag1;
      divisor   <= mag2;
      rem       <= 33'd0;
      quo       <= 32'd0;
      cnt       <= 5'd0;
      iter_done <= 1'b0;
    end else if ((state == CALC) && !flush) begin
      if (!iter_done) begin
        rem       <= keep ? trial[32:0] : shifted[32:0];
        quo       <= {quo[30:0], keep};
        dividend  <= {dividend[30:0], 1'b0};
        cnt       <= cnt + 5'd1;
        iter_done <= (cnt == 5'd31);
      end else begin
        // Sign fix-up gets its own edge so the iteration path stays a bare subtract.
        result    <= final_res;
      end
    end
  end

  assign div_ready     = (state == IDLE);
  assign div_res_valid = (state == DONE);
  assign div_result    = result;
  assign dbg_state     = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random-model bench for div_unit: results, latency, backpressure,
// flush in CALC/DONE, and reset mid-operation.
module tb_div_unit;

  localparam logic [3:0] OP_DIV_W  = 4'b0001;
  localparam logic [3:0] OP_MOD_W  = 4'b0010;
  localparam logic [3:0] OP_DIV_WU = 4'b0100;
  localparam logic [3:0] OP_MOD_WU = 4'b1000;
  localparam int LAT = 33;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        div_valid;
  logic        div_ready;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_res_valid;
  logic        div_res_ready;
  logic [31:0] div_result;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  div_unit dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_op        (div_op),
    .div_src1      (div_src1),
    .div_src2      (div_src2),
    .div_res_valid (div_res_valid),
    .div_res_ready (div_res_ready),
    .div_result    (div_result),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0] | op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return (op[1] | op[3]) ? r : q;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!div_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!div_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: div_ready=%0b after %0d cycles, required 1", div_ready, n);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    @(posedge clk); #1;
    div_valid = 1'b0;
    div_src1  = $urandom;
    div_src2  = $urandom;
    div_op    = 4'b0001 << $urandom_range(0, 3);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!div_res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    div_res_ready = 1'b1;
    @(posedge clk); #1;
    div_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (div_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b, required 1", div_ready);
    end
    vectors++;
    if (div_res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_res_valid: got %0b, required 0", div_res_valid);
    end
    vectors++;
    if (div_result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %h, required 00000000", div_result);
    end
  endtask

  task automatic test_unsigned();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{OP_DIV_WU, 32'd100, 32'd7, 32'd14});
    tbl.push_back('{OP_MOD_WU, 32'd100, 32'd7, 32'd2});
    tbl.push_back('{OP_DIV_WU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
    tbl.push_back('{OP_MOD_WU, 32'hFFFF_FFFF, 32'h10, 32'hF});
    tbl.push_back('{OP_DIV_WU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_result(lat);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL unsigned_latency[%0d]: got %0d cycles, required %0d", i, lat, LAT);
      end
      vectors++;
      if (div_result !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL unsigned_result[%0d]: got %h, required %h", i, div_result, tbl[i].exp);
      end
      consume();
    end
  endtask

  task automatic test_signed();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    tbl.push_back('{OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    tbl.push_back('{OP_MOD_W, 32'd7, 32'hFFFF_FFFE, 32'd1});
    tbl.push_back('{OP_DIV_W, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    tbl.push_back('{OP_DIV_W, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_result(lat);
      vectors++;
      if (div_result !== tbl[i].exp || lat !== LAT) begin
        miscompares++;
        $display("FAIL signed[%0d]: got %h after %0d cycles, required %h after %0d",
                 i, div_result, lat, tbl[i].exp, LAT);
      end
      consume();
    end
  endtask

  task automatic test_corner();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    tbl.push_back('{OP_DIV_WU, 32'd5, 32'd0, 32'hFFFF_FFFF});
    tbl.push_back('{OP_MOD_W, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0});
    tbl.push_back('{OP_DIV_W, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF});
    tbl.push_back('{OP_MOD_WU, 32'd5, 32'd0, 32'd5});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_result(lat);
      vectors++;
      if (div_result !== tbl[i].exp || lat !== LAT) begin
        miscompares++;
        $display("FAIL corner[%0d]: got %h after %0d cycles, required %h after %0d",
                 i, div_result, lat, tbl[i].exp, LAT);
      end
      consume();
      vectors++;
      if (div_ready !== 1'b1 || div_res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL corner_consume[%0d]: ready=%0b res_valid=%0b, required 1/0",
                 i, div_ready, div_res_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(OP_DIV_WU, 32'd1000, 32'd10);
    wait_result(lat);
    vectors++;
    if (div_result !== 32'd100 || lat !== LAT) begin
      miscompares++;
      $display("FAIL bp_result: got %h after %0d cycles, required 00000064 after %0d",
               div_result, lat, LAT);
    end
    for (int c = 0; c < 10; c++) begin
      div_src1 = $urandom;
      div_src2 = $urandom;
      div_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (div_res_valid !== 1'b1 || div_result !== 32'd100 || div_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: res_valid=%0b result=%h ready=%0b, required 1/00000064/0",
                 c, div_res_valid, div_result, div_ready);
      end
    end
    div_valid = 1'b0;
    consume();
    vectors++;
    if (div_ready !== 1'b1 || div_res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready=%0b res_valid=%0b, required 1/0", div_ready, div_res_valid);
    end
  endtask

  task automatic test_flush_calc();
    int lat;
    int seen = 0;
    issue(OP_DIV_WU, 32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    div_valid = 1'b1;
    div_op = OP_DIV_WU;
    @(posedge clk); #1;
    flush = 1'b0;
    div_valid = 1'b0;
    vectors++;
    if (div_ready !== 1'b1 || div_res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_calc_state: ready=%0b res_valid=%0b, required 1/0",
               div_ready, div_res_valid);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (div_res_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_calc_no_result: res_valid seen %0d cycles, required 0", seen);
    end
    issue(OP_DIV_WU, 32'd77, 32'd3);
    wait_result(lat);
    vectors++;
    if (div_result !== 32'd25 || lat !== LAT) begin
      miscompares++;
      $display("FAIL flush_calc_next: got %h after %0d cycles, required 00000019 after %0d",
               div_result, lat, LAT);
    end
    consume();
  endtask

  task automatic test_flush_done();
    int lat;
    int seen = 0;
    issue(OP_DIV_WU, 32'd50, 32'd5);
    wait_result(lat);
    vectors++;
    if (div_result !== 32'd10) begin
      miscompares++;
      $display("FAIL flush_done_pre: got %h, required 0000000a", div_result);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (div_ready !== 1'b1 || div_res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_state: ready=%0b res_valid=%0b, required 1/0",
               div_ready, div_res_valid);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (div_res_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_done_no_result: res_valid seen %0d cycles, required 0", seen);
    end
    issue(OP_DIV_WU, 32'd77, 32'd3);
    wait_result(lat);
    vectors++;
    if (div_result !== 32'd25 || lat !== LAT) begin
      miscompares++;
      $display("FAIL flush_done_next: got %h after %0d cycles, required 00000019 after %0d",
               div_result, lat, LAT);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV_WU, 32'd999, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b0;
    vectors++;
    if (div_ready !== 1'b1 || div_res_valid !== 1'b0 || div_result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%0b res_valid=%0b result=%h, required 1/0/00000000",
               div_ready, div_res_valid, div_result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = $urandom; b = $urandom_range(1, 100); end
        2:       begin a = $urandom; b = 32'hFFFF_FFFF - $urandom_range(0, 50); end
        default: begin a = $urandom; b = (i % 5 == 0) ? 32'd0 : $urandom_range(1, 65535); end
      endcase
      exp = ref_result(op, a, b);
      issue(op, a, b);
      wait_result(lat);
      vectors++;
      if (div_result !== exp || lat !== LAT) begin
        miscompares++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h: got %h after %0d cycles, required %h after %0d",
                 i, op, a, b, div_result, lat, exp, LAT);
      end
      consume();
    end
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    div_valid     = 1'b0;
    div_op        = 4'b0000;
    div_src1      = 32'd0;
    div_src2      = 32'd0;
    div_res_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_backpressure();
    test_flush_calc();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
